// File: rtl/mnist_pkg.sv
// mnist_pkg: sizing constants and FSM encoding shared by the dense layer sequencer.
package mnist_pkg;
  localparam int N_IN = 784;
  localparam int N_OUT = 10;
  localparam int ADDR_W = 13;
  localparam int PIX_W = 10;
  localparam int ACC_W = 26;
  localparam int IDX_W = 4;
  localparam int PROD_W = 17;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, DONE} state_t;
endpackage

// File: rtl/dense_layer_sequencer_if.sv
// dense_layer_sequencer_if: control, memory-read and result-stream signals of the sequencer.
interface dense_layer_sequencer_if;
  import mnist_pkg::*;
  logic start, busy, done, out_valid, out_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic signed [7:0] rom_data;
  logic [PIX_W-1:0] pix_addr;
  logic [7:0] pix_data;
  logic [IDX_W-1:0] out_idx, class_idx;
  logic signed [ACC_W-1:0] out_sum;
  modport master (
    output start, rom_data, pix_data, out_ready,
    input busy, done, rom_addr, pix_addr, out_valid, out_idx, out_sum, class_idx
  );
  modport slave (
    input start, rom_data, pix_data, out_ready,
    output busy, done, rom_addr, pix_addr, out_valid, out_idx, out_sum, class_idx
  );
endinterface

// File: rtl/mac_unit.sv
// mac_unit: registered signed-weight x unsigned-pixel product feeding an accumulator one cycle later.
module mac_unit
  import mnist_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [7:0]       w,
  input  logic        [7:0]       p,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [PROD_W-1:0] prod;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prod <= '0;
      acc <= '0;
    end else if (clr) begin
      prod <= '0;
      acc <= '0;
    end else if (en) begin
      prod <= PROD_W'(w) * PROD_W'($signed({1'b0, p}));
      acc <= acc + ACC_W'(prod);
    end
endmodule

// File: rtl/dense_layer_sequencer.sv
// dense_layer_sequencer: walks N_OUT neurons over N_IN pixels, streams each neuron sum, tracks argmax.
module dense_layer_sequencer
  import mnist_pkg::*;
(
  input logic clk,
  input logic rst_n,
  dense_layer_sequencer_if.slave bus
);
  state_t state, next;
  logic [PIX_W-1:0] i;
  logic [IDX_W-1:0] j, class_idx;
  logic [ADDR_W-1:0] rom_addr;
  logic signed [ACC_W-1:0] acc, max_sum;
  logic fire, last_i, last_j;
  assign fire = state == EMIT && bus.out_ready;
  assign last_i = i == PIX_W'(N_IN - 1);
  assign last_j = j == IDX_W'(N_OUT - 1);
  mac_unit mac (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == IDLE || fire),
    .en(state == RUN || state == DRAIN),
    .w(bus.rom_data),
    .p(bus.pix_data),
    .acc(acc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = bus.start ? RUN : IDLE;
      RUN: next = last_i ? DRAIN : RUN;
      DRAIN: next = EMIT;
      EMIT: next = bus.out_ready ? (last_j ? DONE : RUN) : EMIT;
      default: next = IDLE;
    endcase
  end
  // Address steps on the last pixel are deferred to the handshake so rom_addr never passes the final weight.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      i <= '0;
      j <= '0;
      rom_addr <= '0;
      max_sum <= '0;
      class_idx <= '0;
    end else if (state == RUN && !last_i) begin
      i <= i + PIX_W'(1);
      rom_addr <= rom_addr + ADDR_W'(1);
    end else if (fire) begin
      i <= '0;
      if (!last_j) begin
        j <= j + IDX_W'(1);
        rom_addr <= rom_addr + ADDR_W'(1);
      end
      if (j == '0 || acc > max_sum) begin
        max_sum <= acc;
        class_idx <= j;
      end
    end else if (state == DONE) begin
      j <= '0;
      rom_addr <= '0;
    end
  always_comb begin
    bus.busy = state == RUN || state == DRAIN || state == EMIT;
    bus.done = state == DONE;
    bus.out_valid = state == EMIT;
    bus.rom_addr = rom_addr;
    bus.pix_addr = i;
    bus.out_idx = j;
    bus.out_sum = acc;
    bus.class_idx = class_idx;
  end
endmodule

// File: tb/tb_dense_layer_sequencer.sv
// tb_dense_layer_sequencer: directed checks of sums, argmax, latency, backpressure, restart and reset.
module tb_dense_layer_sequencer;
  import mnist_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int cyc = 0, passed = 0, total = 0;
  int hs_cnt = 0, done_cnt = 0, gap_err = 0, max_addr = 0, prev_addr = 0, stall_err = 0;
  int sc, dc, n;
  logic signed [ACC_W-1:0] sums [0:15];
  logic [IDX_W-1:0] idxs [0:15];
  logic signed [7:0] rom [0:8191];
  logic [7:0] pix [0:1023];
  logic signed [ACC_W-1:0] cap_sum;
  logic [IDX_W-1:0] cap_idx;
  logic [ADDR_W-1:0] cap_rom;
  logic [PIX_W-1:0] cap_pix;
  dense_layer_sequencer_if bus();
  dense_layer_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.rom_data = rom[bus.rom_addr];
  assign bus.pix_data = pix[bus.pix_addr];
  always @(negedge clk)
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready && hs_cnt < 16) begin
        sums[hs_cnt] = bus.out_sum;
        idxs[hs_cnt] = bus.out_idx;
        hs_cnt++;
      end
      if (bus.done) done_cnt++;
      if (int'(bus.rom_addr) != prev_addr) begin
        if (int'(bus.rom_addr) != prev_addr + 1 && bus.rom_addr != '0) gap_err++;
        prev_addr = int'(bus.rom_addr);
      end
      if (int'(bus.rom_addr) > max_addr) max_addr = int'(bus.rom_addr);
    end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic fill(input bit ramp, input int wval, input int pval);
    for (int a = 0; a < 8192; a++)
      rom[a] = (a >= N_IN * N_OUT) ? 8'sd0 : 8'(ramp ? (a / N_IN - 5) : wval);
    for (int a = 0; a < 1024; a++) pix[a] = 8'(pval);
  endtask

  task automatic start_run(output int s);
    @(negedge clk);
    hs_cnt = 0;
    done_cnt = 0;
    gap_err = 0;
    max_addr = 0;
    prev_addr = 0;
    bus.start = 1'b1;
    s = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int d);
    int k = 0;
    while (!bus.done && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", bus.done, 1);
    d = cyc;
  endtask

  task automatic check_sums(input bit ramp, input int w, input int p, input string tag);
    chk({tag, "_handshakes"}, hs_cnt, 10);
    for (int k = 0; k < 10; k++) begin
      chk({tag, "_idx"}, idxs[k], k);
      chk({tag, "_sum"}, sums[k], (ramp ? k - 5 : w) * p * N_IN);
    end
    chk({tag, "_max_addr"}, max_addr, 7839);
    chk({tag, "_addr_gaps"}, gap_err, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    fill(0, 1, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_pix_addr", bus.pix_addr, 0);
    chk("rst_sum", bus.out_sum, 0);
    chk("rst_class", bus.class_idx, 0);
    rst_n = 1'b1;
    // all-ones image: every neuron ties, lowest index wins
    start_run(sc);
    wait_done(dc);
    chk("t1_latency", dc - sc, 7861);
    chk("t1_class", bus.class_idx, 0);
    chk("t1_busy_in_done", bus.busy, 0);
    @(negedge clk);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_idle_rom_addr", bus.rom_addr, 0);
    check_sums(0, 1, 1, "t1");
    fill(0, 127, 255);
    start_run(sc);
    wait_done(dc);
    chk("t2a_class", bus.class_idx, 0);
    @(negedge clk);
    check_sums(0, 127, 255, "t2a");
    fill(0, -128, 255);
    start_run(sc);
    wait_done(dc);
    chk("t2b_class", bus.class_idx, 0);
    @(negedge clk);
    check_sums(0, -128, 255, "t2b");
    fill(1, 0, 1);
    start_run(sc);
    wait_done(dc);
    chk("t3_class", bus.class_idx, 9);
    @(negedge clk);
    check_sums(1, 0, 1, "t3");
    repeat (5) @(negedge clk);
    chk("t3_class_held", bus.class_idx, 9);
    // backpressure: hold off the consumer for 20 cycles on neuron 3
    start_run(sc);
    n = 0;
    while (bus.out_idx != 4'd3 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_idx3", bus.out_idx, 3);
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_valid_seen", bus.out_valid, 1);
    cap_sum = bus.out_sum;
    cap_idx = bus.out_idx;
    cap_rom = bus.rom_addr;
    cap_pix = bus.pix_addr;
    stall_err = 0;
    repeat (20) begin
      if (!bus.out_valid || bus.out_sum !== cap_sum || bus.out_idx !== cap_idx ||
          bus.rom_addr !== cap_rom || bus.pix_addr !== cap_pix) stall_err++;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    chk("t4_stall_stable", stall_err, 0);
    chk("t4_stall_idx", cap_idx, 3);
    chk("t4_stall_sum", cap_sum, -2 * 784);
    chk("t4_stall_rom_addr", cap_rom, 3135);
    chk("t4_stall_pix_addr", cap_pix, 783);
    wait_done(dc);
    chk("t4_latency", dc - sc, 7881);
    @(negedge clk);
    check_sums(1, 0, 1, "t4");
    // restart attempts mid-run and in the done cycle are ignored
    fill(0, 1, 1);
    start_run(sc);
    repeat (100) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(dc);
    chk("t5_latency", dc - sc, 7861);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t5_start_in_done_ignored", bus.busy, 0);
    chk("t5_done_pulses", done_cnt, 1);
    check_sums(0, 1, 1, "t5");
    // reset in the middle of neuron 5
    fill(1, 0, 1);
    start_run(sc);
    n = 0;
    while (bus.out_idx != 4'd5 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_idx5", bus.out_idx, 5);
    repeat (50) @(negedge clk);
    chk("t6_class_before_rst", bus.class_idx, 4);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_rom_addr", bus.rom_addr, 0);
    chk("t6_rst_pix_addr", bus.pix_addr, 0);
    chk("t6_rst_idx", bus.out_idx, 0);
    chk("t6_rst_sum", bus.out_sum, 0);
    chk("t6_rst_class", bus.class_idx, 0);
    repeat (3) @(negedge clk);
    chk("t6_no_done", done_cnt, 0);
    rst_n = 1'b1;
    fill(0, 1, 1);
    start_run(sc);
    wait_done(dc);
    chk("t6_latency", dc - sc, 7861);
    chk("t6_class", bus.class_idx, 0);
    @(negedge clk);
    chk("t6_done_pulses", done_cnt, 1);
    check_sums(0, 1, 1, "t6");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
